// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift extractor: FSM state encoding and the
// default word / count widths used as parameter defaults.
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_window_select.sv
// ---------------------------------------------------------------------------
// shift_window_select
// Purely combinational funnel: picks WIDTH bits out of a 2*WIDTH window,
// starting at bit 'offset'. The lower-indexed word sits in the low half.
//
// Ports:
//   window  in  [2*WIDTH-1:0]  {newer word, older word}
//   offset  in  [clog2(WIDTH)-1:0] bit offset into the window
//   slice   out [WIDTH-1:0]    window[offset +: WIDTH]
// ---------------------------------------------------------------------------
module shift_window_select
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0]         window,
  input  logic [$clog2(WIDTH)-1:0]   offset,
  output logic [WIDTH-1:0]           slice
);

  // offset <= WIDTH-1, so the slice never runs past the top of the window.
  assign slice = window[offset +: WIDTH];

endmodule

// File: rtl/shift_extractor.sv
// ---------------------------------------------------------------------------
// shift_extractor
// Re-aligns a word stream that carries data at a fixed bit offset: output
// word k is bits [offset+WIDTH-1:offset] of {in_word[k+1], in_word[k]}.
// With a non-zero offset one extra input word is consumed up front (PRIME)
// to fill the hold register; with offset 0 words pass straight through.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. out_valid/out_data stay stable until out_ready is seen; in_ready
// never depends on in_valid.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               job launch, sampled only in IDLE
//   offset, count       job parameters, captured on start
//   in_data/valid/ready input word stream
//   out_data/valid/ready extracted word stream
//   busy                FSM not in IDLE
//   done                one-cycle completion pulse
//   abort               (only with SHIFT_EXTRACTOR_ABORT_EN) drop the job
//
// Build option: define SHIFT_EXTRACTOR_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module shift_extractor
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(WIDTH)-1:0] offset,
  input  logic [CNT_W-1:0]         count,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
`ifdef SHIFT_EXTRACTOR_ABORT_EN
  ,
  input  logic                     abort
`endif
);

  localparam int OFF_W = $clog2(WIDTH);

  shift_state_e     state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] load_left_q, load_left_d;  // outputs still to be loaded
  logic [CNT_W-1:0] out_left_q, out_left_d;    // outputs still to be handed off
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic             abort_w, abort_act;
  logic             in_ready_w, busy_w;
  logic             in_fire, out_fire;
  logic [WIDTH-1:0] slice, funnel;

`ifdef SHIFT_EXTRACTOR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign abort_act = abort_w && busy_w;
  assign in_fire   = in_valid && in_ready_w;
  assign out_fire  = out_valid_q && out_ready;

  shift_window_select #(.WIDTH(WIDTH)) u_window_select (
    .window ({in_data, hold_q}),
    .offset (off_q),
    .slice  (slice)
  );

  // With offset 0 the hold register is never primed; the word is the output.
  assign funnel = (off_q == '0) ? in_data : slice;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (count != '0))
          state_d = (offset != '0) ? ST_PRIME : ST_STREAM;
      end
      ST_PRIME: begin
        if (in_fire) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_fire && (out_left_q == CNT_W'(1))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) state_d = ST_IDLE;
  end

  // FSM outputs
  always_comb begin
    busy_w     = (state_q != ST_IDLE);
    in_ready_w = 1'b0;
    unique case (state_q)
      ST_PRIME:  in_ready_w = 1'b1;
      // Stop accepting once every output word has been loaded, so exactly
      // count (+1 when primed) input words are consumed.
      ST_STREAM: in_ready_w = (load_left_q != '0) && (!out_valid_q || out_ready);
      default:   in_ready_w = 1'b0;
    endcase
    if (reset || abort_w) in_ready_w = 1'b0;
  end

  // Datapath next values
  always_comb begin
    off_d       = off_q;
    load_left_d = load_left_q;
    out_left_d  = out_left_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          off_d       = offset;
          load_left_d = count;
          out_left_d  = count;
          done_d      = (count == '0);
        end
      end
      ST_PRIME: begin
        if (in_fire) hold_d = in_data;
      end
      ST_STREAM: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_left_d  = out_left_q - CNT_W'(1);
          done_d      = (out_left_q == CNT_W'(1));
        end
        // A load in the same cycle as a hand-off refills the output slot.
        if (in_fire) begin
          out_data_d  = funnel;
          out_valid_d = 1'b1;
          hold_d      = in_data;
          load_left_d = load_left_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    if (abort_act) begin
      out_valid_d = 1'b0;
      load_left_d = '0;
      out_left_d  = '0;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      off_q       <= '0;
      load_left_q <= '0;
      out_left_q  <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      off_q       <= off_d;
      load_left_q <= load_left_d;
      out_left_q  <= out_left_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_w;
  assign busy      = busy_w;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shift_extractor.sv
// ---------------------------------------------------------------------------
// tb_shift_extractor
// Randomized self-checking bench for shift_extractor. The reference treats
// the input words as one continuous little-endian bit stream: output word k
// is the WIDTH bits starting at stream bit k*WIDTH + offset.
// Define SHIFT_EXTRACTOR_ABORT_EN for both the bench and the RTL to cover
// the abort input.
// ---------------------------------------------------------------------------
module tb_shift_extractor;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [4:0]    offset;
  logic [CW-1:0] count;
  logic [W-1:0]  in_data, out_data;
  logic          in_valid, in_ready, out_valid, out_ready, busy, done;
`ifdef SHIFT_EXTRACTOR_ABORT_EN
  logic          abort;
`endif

  shift_extractor #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .offset    (offset),
    .count     (count),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
`ifdef SHIFT_EXTRACTOR_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  int           n_total = 0;
  int           n_pass  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] job_words[$];
  logic [W-1:0] fixed_words[$];
  logic [W-1:0] fixed_exp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: bit b of output k is stream bit k*W + off + b.
  function automatic logic [W-1:0] ref_word(input int off, input int k);
    logic [W-1:0] r;
    logic [W-1:0] w;
    int pos;
    for (int b = 0; b < W; b++) begin
      pos  = k * W + off + b;
      w    = job_words[pos / W];
      r[b] = w[pos % W];
    end
    return r;
  endfunction

  // Driver tasks
  task automatic idle_inputs();
    start     = 1'b0;
    offset    = '0;
    count     = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef SHIFT_EXTRACTOR_ABORT_EN
    abort     = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_job(input int off, input int cnt);
    int n_in;
    n_in = cnt + ((off != 0) ? 1 : 0);
    job_words.delete();
    exp_q.delete();
    for (int i = 0; i < n_in; i++)
      job_words.push_back((fixed_words.size() > i) ? fixed_words[i] : W'($urandom));
    for (int k = 0; k < cnt; k++)
      exp_q.push_back((fixed_exp.size() > k) ? fixed_exp[k] : ref_word(off, k));
    fixed_words.delete();
    fixed_exp.delete();
  endtask

  // Full job with random valid gaps, random back-pressure and a garbage start
  // held high throughout (it must be ignored, including on the final cycle).
  task automatic run_job(input int off, input int cnt, input int ready_pct, input int stall_at);
    int n_in, idx, outs, stall_left;
    bit stalled, hold_prev, want_valid, finished;
    logic [W-1:0] prev_data;
    n_in = cnt + ((off != 0) ? 1 : 0);
    load_job(off, cnt);
    @(negedge clk);
    start = 1'b1; offset = 5'(off); count = CW'(cnt); in_valid = 1'b0; out_ready = 1'b0;
    idx = 0; outs = 0; stall_left = 0; stalled = 0; hold_prev = 0;
    want_valid = 0; finished = 0; prev_data = '0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start  = 1'b1;
      offset = 5'($urandom_range(0, 31));
      count  = CW'($urandom_range(1, 255));
      if (idx < n_in) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = job_words[idx];
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
      end
      if (!stalled && outs == stall_at && out_valid) begin
        stalled    = 1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      #1;
      if (cyc == 0) check("busy_after_start", busy, 1);
      if (want_valid) check("latency_valid", out_valid, 1);
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
      if (idx >= n_in && in_valid) check("extra_input", in_ready, 0);
      check("done_early", done, 0);
      want_valid = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("out_data", out_data, exp_q.pop_front());
        outs++;
        if (outs >= cnt) finished = 1;
      end
      if (in_valid && in_ready && idx < n_in) begin
        want_valid = (off == 0) || (idx > 0);
        idx++;
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
    if (!finished) begin
      check("job_timeout", 0, 1);
      apply_reset();
    end else begin
      @(negedge clk);
      idle_inputs();
      #1;
      check("done_pulse", done, 1);
      check("idle_after_done", busy, 0);
      check("inputs_used", idx, n_in);
      @(negedge clk);
      #1;
      check("done_single", done, 0);
    end
  endtask

  task automatic count_zero_job();
    @(negedge clk);
    start = 1'b1; offset = 5'd7; count = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("cnt0_busy", busy, 0);
    check("cnt0_done", done, 1);
    @(negedge clk);
    #1;
    check("cnt0_done_single", done, 0);
    check("cnt0_busy_after", busy, 0);
  endtask

  // Runs a job up to its first output hand-off and returns on the negedge
  // after that hand-off.
  task automatic first_output(input int off, input string tag);
    int idx;
    bit got_one;
    load_job(off, 4);
    idx = 0; got_one = 0;
    @(negedge clk);
    start = 1'b1; offset = 5'(off); count = CW'(4);
    for (int cyc = 0; cyc < 50 && !got_one; cyc++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_data = job_words[(idx < job_words.size()) ? idx : 0];
      #1;
      if (out_valid && out_ready) begin
        check(tag, out_data, exp_q.pop_front());
        got_one = 1;
      end
      if (in_valid && in_ready) idx++;
    end
    if (!got_one) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_mid_job();
    first_output(12, "rst_first_out");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    #1;
    check("rst_no_done", done, 0);
  endtask

`ifdef SHIFT_EXTRACTOR_ABORT_EN
  task automatic abort_mid_job();
    first_output(20, "abort_first_out");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 1);
    @(negedge clk);
    #1;
    check("abort_done_single", done, 0);
  endtask
`endif

  initial begin
    idle_inputs();
    reset = 1'b1;
    apply_reset();
    #1;
    check("rst_in_ready0", in_ready, 0);
    check("rst_out_valid0", out_valid, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_out_data0", out_data, 0);

    // Pass-through at offset 0
    fixed_words = '{32'h11111111, 32'h22222222};
    fixed_exp   = '{32'h11111111, 32'h22222222};
    run_job(0, 2, 100, -1);

    // Byte offset
    fixed_words = '{32'hAABBCCDD, 32'h11223344};
    fixed_exp   = '{32'h44AABBCC};
    run_job(8, 1, 100, -1);

    // Back-pressure held for five cycles at the second output
    run_job(4, 3, 100, 1);

    count_zero_job();

    reset_mid_job();
    run_job(12, 4, 80, -1);

    // Widest offset and a single-word job
    run_job(31, 3, 70, -1);
    run_job(1, 1, 50, -1);

`ifdef SHIFT_EXTRACTOR_ABORT_EN
    abort_mid_job();
    run_job(5, 3, 90, -1);
`endif

    for (int j = 0; j < 25; j++) begin
      int off;
      off = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
      run_job(off, int'($urandom_range(1, 6)), int'($urandom_range(30, 100)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_extractor.md
SHIFT_EXTRACTOR -- requirements
Module: shift_extractor

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the input and output word width; the offset width SHALL be $clog2(WIDTH).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the output-word count.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: job launch pulse, sampled only in IDLE.
REQ-006 Port offset, input, 5 bits: bit offset 0..31, captured on start.
REQ-007 Port count, input, CNT_W bits: number of output words, captured on start.
REQ-008 Ports in_data (WIDTH), in_valid (1) input and in_ready (1) output: the input word stream.
REQ-009 Ports out_data (WIDTH), out_valid (1) output and out_ready (1) input: the extracted word stream.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse on completion of a job.

Function
REQ-012 The block SHALL be the inverse of the codebase's shift expander: output word k = bits [offset+31:offset] of {in_word[k+1], in_word[k]}, with the lower-indexed word in the low half.
REQ-013 A transfer SHALL occur only on a cycle where valid and ready are both high.
REQ-014 FSM states SHALL be IDLE, PRIME, STREAM.
REQ-015 IDLE to PRIME SHALL occur on start with count != 0 and offset != 0.
REQ-016 IDLE to STREAM SHALL occur on start with count != 0 and offset == 0.
REQ-017 start with count == 0 SHALL stay in IDLE and pulse done on the next cycle.
REQ-018 PRIME: in_ready = 1; the accepted word SHALL be stored in the hold register, then the FSM SHALL go to STREAM.
REQ-019 STREAM: in_ready = !out_valid || out_ready.
REQ-020 In STREAM, each accepted input SHALL load out_data with the funnel result, set out_valid on the next cycle, and replace the hold register with the accepted word.
REQ-021 Latency from the completing input handshake to out_valid SHALL be 1 cycle, giving full throughput of one word per cycle.
REQ-022 out_valid and out_data SHALL hold stable until out_ready is seen.
REQ-023 Input words consumed SHALL be count+1 when offset != 0 and count when offset == 0.
REQ-024 On the output handshake of the final word, the block SHALL return to IDLE with done = 1 on the following cycle; start on that same cycle SHALL be ignored.
REQ-025 start while busy SHALL be ignored, and offset/count changes while busy SHALL have no effect.
REQ-026 A simultaneous output handshake and new input acceptance SHALL both complete in the same cycle.

Reset
REQ-027 On reset the FSM SHALL go to IDLE and in_ready, out_valid, busy and done SHALL be 0.
REQ-028 On reset out_data, the hold register and the remaining counter SHALL be 0.
REQ-029 Reset mid-job SHALL discard all held data and emit no done pulse.

Configuration
REQ-030 Macro SHIFT_EXTRACTOR_ABORT_EN, when defined, SHALL add input port abort (1 bit).
REQ-031 With the macro defined, abort SHALL return the FSM to IDLE on the next cycle, clear out_valid, and pulse done; abort SHALL take priority over all handshakes.
REQ-032 Without the macro the port SHALL be absent and the behaviour SHALL be identical to abort tied to 0.

Structure
REQ-033 Package shift_pkg SHALL hold the FSM state enum typedef and the default WIDTH/CNT_W constants.
REQ-034 Combinational sub-module shift_window_select SHALL take a 2*WIDTH window and an offset and produce the WIDTH-bit extracted slice.

Verification
REQ-035 Offset 0, count 2, inputs 0x11111111 and 0x22222222 -> outputs 0x11111111 and 0x22222222, then done.
REQ-036 Offset 8, count 1, inputs 0xAABBCCDD and 0x11223344 -> output 0x44AABBCC.
REQ-037 Offset 4, count 3, out_ready held 0 for 5 cycles at the second output -> out_data stable, in_ready 0, no data lost.
REQ-038 count 0 with start -> busy stays 0 and done pulses 1 cycle later.
REQ-039 Reset asserted after the first output of a count-4 job -> IDLE, out_valid 0, no done; a new job then runs correctly.
REQ-040 With SHIFT_EXTRACTOR_ABORT_EN defined, abort in STREAM -> IDLE next cycle, done pulses, out_valid 0.
